// File: rtl/load_store_initiator.sv
// Data-memory bus initiator: one load/store per instruction over req/gnt/rvalid.
// Stalls the pipeline until completion; returns extended load data or an error pulse.
module load_store_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  Rd_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        access_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R
    } state_t;

    localparam bit             TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [29:0]       word_q, word_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    logic        req_any;
    logic        f3_ok;
    logic        align_ok;
    logic        legal;
    logic        start;
    logic        done_st;
    logic        done_ld;
    logic        hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_ext;

    // Request legality: funct3 valid for the op, natural alignment, not both ops
    always_comb begin
        req_any = Ctl_MemRead_in | Ctl_MemWrite_in;
        f3_ok   = 1'b0;
        case (funct3_in)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~Ctl_MemWrite_in;
            default:                f3_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        case (funct3_in[1:0])
            2'b01:   align_ok = ~addr_in[0];
            2'b10:   align_ok = (addr_in[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = f3_ok & align_ok & ~(Ctl_MemRead_in & Ctl_MemWrite_in);
        start = (state_q == S_IDLE) & req_any & legal;
    end

    // Store lane placement; loads always fetch the whole word
    always_comb begin
        be_new    = 4'hF;
        wdata_new = wdata_in;
        if (Ctl_MemWrite_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << addr_in[1:0];
                    wdata_new = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << addr_in[1:0];
                    wdata_new = {2{wdata_in[15:0]}};
                end
                default: begin
                    be_new    = 4'hF;
                    wdata_new = wdata_in;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ld_ext = {24'd0, byte_sel};
            3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  ld_ext = {16'd0, half_sel};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Completion, timeout and stall; completion beats a same-cycle timeout
    always_comb begin
        done_st = (state_q == S_REQ) & mem_gnt & we_q;
        done_ld = ((state_q == S_REQ) & mem_gnt & ~we_q & mem_rvalid)
                | ((state_q == S_WAIT_R) & mem_rvalid);
        hit     = TO_EN & (state_q != S_IDLE) & (cnt_q == LAST)
                & ~done_st & ~done_ld;
        stall   = start
                | ((state_q == S_REQ) & ~(mem_gnt & (we_q | mem_rvalid)) & ~hit)
                | ((state_q == S_WAIT_R) & ~mem_rvalid & ~hit);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        off_d      = off_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        ld_valid_d = 1'b0;
        ld_data_d  = ld_data_q;
        ld_rd_d    = ld_rd_q;
        aerr_d     = 1'b0;
        berr_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    word_d  = addr_in[31:2];
                    off_d   = addr_in[1:0];
                    we_d    = Ctl_MemWrite_in;
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    f3_d    = funct3_in;
                    rd_d    = Rd_in;
                end else if (req_any) begin
                    aerr_d = 1'b1;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_st) begin
                    state_d = S_IDLE;
                end else if (done_ld) begin
                    state_d    = S_IDLE;
                    ld_valid_d = 1'b1;
                    ld_data_d  = ld_ext;
                    ld_rd_d    = rd_q;
                end else if (hit) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                end else if (mem_gnt) begin
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_ld) begin
                    state_d    = S_IDLE;
                    ld_valid_d = 1'b1;
                    ld_data_d  = ld_ext;
                    ld_rd_d    = rd_q;
                end else if (hit) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            ld_rd_q    <= '0;
            aerr_q     <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            off_q      <= off_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            ld_valid_q <= ld_valid_d;
            ld_data_q  <= ld_data_d;
            ld_rd_q    <= ld_rd_d;
            aerr_q     <= aerr_d;
            berr_q     <= berr_d;
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_we     = we_q;
    assign mem_addr   = {word_q, 2'b00};
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign ld_valid   = ld_valid_q;
    assign ld_data    = ld_data_q;
    assign ld_rd      = ld_rd_q;
    assign access_err = aerr_q;
    assign bus_err    = berr_q;

endmodule

// File: tb/tb_load_store_initiator.sv
// Scoreboard bench for load_store_initiator (TIMEOUT=4).
// Stimulus queues expected bus/load/error events; a negedge monitor consumes them.
module tb_load_store_initiator;

    localparam logic [1:0] K_BUS  = 2'd0;
    localparam logic [1:0] K_LD   = 2'd1;
    localparam logic [1:0] K_AERR = 2'd2;
    localparam logic [1:0] K_BERR = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_i, wr_i;
    logic [2:0]  f3_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rdr_i;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        access_err, bus_err;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int passed = 0;

    load_store_initiator #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .Ctl_MemRead_in(rd_i), .Ctl_MemWrite_in(wr_i),
        .funct3_in(f3_i), .addr_in(addr_i), .wdata_in(wdata_i), .Rd_in(rdr_i),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd),
        .access_err(access_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic take(input logic [1:0] k);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = sb_q.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        if (k == K_BUS && e.kind == K_BUS) begin
            chk("mem_addr", mem_addr, e.a);
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_be", 32'(mem_be), 32'(e.be));
            if (e.we) chk("mem_wdata", mem_wdata, e.d);
        end
        if (k == K_LD && e.kind == K_LD) begin
            chk("ld_data", ld_data, e.d);
            chk("ld_rd", 32'(ld_rd), 32'(e.rd));
        end
    endtask

    always @(negedge clk) begin
        if (mem_req && mem_gnt) take(K_BUS);
        if (ld_valid) take(K_LD);
        if (access_err) take(K_AERR);
        if (bus_err) take(K_BERR);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rr);
        rd_i = r; wr_i = w; f3_i = f; addr_i = a; wdata_i = wd; rdr_i = rr;
    endtask

    task automatic clear();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic xact(input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rr, input int gw, input int rw,
                        input logic [31:0] rdata, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] eld);
        sb_q.push_back(exp_t'{K_BUS, {a[31:2], 2'b00}, w, ebe, ewd, 5'd0});
        if (r) sb_q.push_back(exp_t'{K_LD, 32'd0, 1'b0, 4'd0, eld, rr});
        drive(r, w, f, a, wd, rr);
        @(negedge clk);
        chk("stall_start", 32'(stall), 32'd1);
        chk("req_start", 32'(mem_req), 32'd0);
        tick();
        clear();
        repeat (gw) begin
            @(negedge clk);
            chk("stall_wait_gnt", 32'(stall), 32'd1);
            chk("req_wait_gnt", 32'(mem_req), 32'd1);
            tick();
        end
        mem_gnt = 1'b1;
        if (w) begin
            @(negedge clk);
            chk("stall_st_done", 32'(stall), 32'd0);
            tick();
            mem_gnt = 1'b0;
        end else if (rw == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            chk("stall_ld_done", 32'(stall), 32'd0);
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end else begin
            @(negedge clk);
            chk("stall_gnt_rd", 32'(stall), 32'd1);
            tick();
            mem_gnt = 1'b0;
            repeat (rw - 1) begin
                @(negedge clk);
                chk("stall_wait_r", 32'(stall), 32'd1);
                chk("req_wait_r", 32'(mem_req), 32'd0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            chk("stall_ld_done", 32'(stall), 32'd0);
            tick();
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic bad(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a);
        sb_q.push_back(exp_t'{K_AERR, 32'd0, 1'b0, 4'd0, 32'd0, 5'd0});
        drive(r, w, f, a, 32'hFFFF_FFFF, 5'd31);
        @(negedge clk);
        chk("stall_illegal", 32'(stall), 32'd0);
        chk("req_illegal", 32'(mem_req), 32'd0);
        tick();
        clear();
        @(negedge clk);
        chk("req_after_illegal", 32'(mem_req), 32'd0);
        tick();
    endtask

    initial begin
        reset      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        clear();
        #3;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_errs", {30'd0, access_err, bus_err}, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // LW 0x100: gnt in first REQ cycle, rvalid two cycles later
        xact(1, 0, 3'b010, 32'h100, 32'd0, 5'd5, 0, 2,
             32'hDEADBEEF, 4'hF, 32'd0, 32'hDEADBEEF);
        tick();

        // SB 0x103: immediate gnt, single REQ cycle
        xact(0, 1, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 0, 0,
             32'd0, 4'b1000, 32'hA5A5A5A5, 32'd0);
        @(negedge clk);
        chk("req_after_sb", 32'(mem_req), 32'd0);
        chk("ld_data_hold", ld_data, 32'hDEADBEEF);
        tick();

        // Other stores
        xact(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd0, 1, 0,
             32'd0, 4'b1100, 32'hABCDABCD, 32'd0);
        xact(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd0, 0, 0,
             32'd0, 4'hF, 32'hCAFEF00D, 32'd0);
        tick();

        // Sub-word loads of 0x80F17F82, issued back to back
        xact(1, 0, 3'b000, 32'h200, 32'd0, 5'd1, 0, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'hFFFFFF82);
        xact(1, 0, 3'b100, 32'h200, 32'd0, 5'd2, 0, 1,
             32'h80F17F82, 4'hF, 32'd0, 32'h00000082);
        xact(1, 0, 3'b001, 32'h202, 32'd0, 5'd3, 1, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'hFFFF80F1);
        xact(1, 0, 3'b101, 32'h202, 32'd0, 5'd4, 0, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'h000080F1);
        xact(1, 0, 3'b100, 32'h201, 32'd0, 5'd6, 0, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'h0000007F);
        xact(1, 0, 3'b000, 32'h203, 32'd0, 5'd8, 0, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'hFFFFFF80);
        xact(1, 0, 3'b001, 32'h200, 32'd0, 5'd9, 0, 0,
             32'h80F17F82, 4'hF, 32'd0, 32'h00007F82);
        tick();

        // Illegal requests
        bad(1, 0, 3'b010, 32'h102);
        bad(0, 1, 3'b001, 32'h101);
        bad(1, 0, 3'b011, 32'h100);
        bad(1, 1, 3'b010, 32'h100);
        bad(0, 1, 3'b100, 32'h100);

        // Timeout: no gnt, bus_err after 4th REQ cycle
        sb_q.push_back(exp_t'{K_BERR, 32'd0, 1'b0, 4'd0, 32'd0, 5'd0});
        drive(1, 0, 3'b010, 32'h300, 32'd0, 5'd11);
        @(negedge clk);
        chk("stall_to_start", 32'(stall), 32'd1);
        tick();
        clear();
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("stall_to_req", 32'(stall), 32'd1);
            chk("req_to_req", 32'(mem_req), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("stall_to_hit", 32'(stall), 32'd0);
        chk("req_to_hit", 32'(mem_req), 32'd1);
        tick();
        @(negedge clk);
        chk("req_after_to", 32'(mem_req), 32'd0);
        chk("stall_after_to", 32'(stall), 32'd0);
        chk("ld_valid_after_to", 32'(ld_valid), 32'd0);
        tick();

        // Completion on the 4th busy cycle beats the timeout
        xact(1, 0, 3'b010, 32'h304, 32'd0, 5'd12, 0, 3,
             32'h12345678, 4'hF, 32'd0, 32'h12345678);
        xact(0, 1, 3'b010, 32'h308, 32'h55AA55AA, 5'd0, 3, 0,
             32'd0, 4'hF, 32'h55AA55AA, 32'd0);
        tick();

        // Asynchronous reset during WAIT_R
        sb_q.push_back(exp_t'{K_BUS, 32'h400, 1'b0, 4'hF, 32'd0, 5'd0});
        drive(1, 0, 3'b010, 32'h400, 32'd0, 5'd7);
        tick();
        clear();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #1;
        chk("stall_wait_pre_rst", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'd0);
        chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_async_ld_data", ld_data, 32'd0);
        tick();
        reset = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_rvalid_ignored", 32'(ld_valid), 32'd0);
        tick();
        xact(1, 0, 3'b010, 32'h404, 32'd0, 5'd10, 1, 1,
             32'h0BADF00D, 4'hF, 32'd0, 32'h0BADF00D);
        tick();
        tick();

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
